muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RV32M op set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the execute stage. It sits beside the single-cycle ALU and is used for M-extension instructions. Compared with the combinational ALU it adds configurable width, valid/ready handshakes on both sides, multi-cycle sequencing, and flush support. Like the ALU, it reports negative and zero flags on its result.

---
 rtl/muldiv_unit_if.sv | 21 ++
 rtl/muldiv_unit.sv | 97 +++++++++
 tb/tb_muldiv_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand/op request and result/flag response bundle for muldiv_unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] inputA;
    logic [WIDTH-1:0] inputB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    modport master (
        output in_valid, op, inputA, inputB, out_ready,
        input  in_ready, out_valid, result, negative, zero
    );
    modport slave (
        input  in_valid, op, inputA, inputB, out_ready,
        output in_ready, out_valid, result, negative, zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (shift-add / restoring), one bit per cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input logic          clk,
    input logic          nRst,
    input logic          flush,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   b_q, b_d, result_q, result_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic               a_sgn, b_sgn, div_zero, div_ovf;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [WIDTH:0]     msum, dtry;
    logic [2*WIDTH-1:0] step, prod_fix;
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            b_q       <= '0;
            result_q  <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            b_q       <= b_d;
            result_q  <= result_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end
    always_comb begin
        a_sgn    = (bus.op inside {3'b001, 3'b010, 3'b100, 3'b110}) & bus.inputA[WIDTH-1];
        b_sgn    = (bus.op inside {3'b001, 3'b100, 3'b110}) & bus.inputB[WIDTH-1];
        a_mag    = a_sgn ? -bus.inputA : bus.inputA;
        b_mag    = b_sgn ? -bus.inputB : bus.inputB;
        div_zero = bus.op[2] & (bus.inputB == '0);
        div_ovf  = bus.op[2] & ~bus.op[0] & (bus.inputA == MIN) & (&bus.inputB);
        // prod_q holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV
        msum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, b_q} : '0);
        dtry     = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]} - {1'b0, b_q};
        step     = !op_q[2] ? {msum, prod_q[WIDTH-1:1]} :
                   dtry[WIDTH] ? {prod_q[2*WIDTH-2:0], 1'b0} :
                   {dtry[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        prod_fix = neg_res_q ? -prod_q : prod_q;
        quo      = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem      = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
        state_d   = state_q;
        op_d      = op_q;
        b_d       = b_q;
        result_d  = result_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        if (flush) begin
            state_d = IDLE;
        end else if (state_q == IDLE && bus.in_valid) begin
            op_d      = bus.op;
            b_d       = b_mag;
            prod_d    = {{WIDTH{1'b0}}, a_mag};
            cnt_d     = '0;
            neg_res_d = a_sgn ^ b_sgn;
            neg_rem_d = a_sgn;
            result_d  = div_zero ? (bus.op[1] ? bus.inputA : '1) :
                        div_ovf ? (bus.op[1] ? '0 : MIN) : result_q;
            state_d   = (div_zero | div_ovf) ? DONE : CALC;
        end else if (state_q == CALC) begin
            prod_d  = step;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FIX : CALC;
        end else if (state_q == FIX) begin
            result_d = op_q[2] ? (op_q[1] ? rem : quo) :
                       (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
            state_d  = DONE;
        end else if (state_q == DONE && bus.out_ready) begin
            state_d = IDLE;
        end
    end
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.negative  = result_q[WIDTH-1];
    assign bus.zero      = (result_q == '0);
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit with immediate-assertion checks.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic flush = 1'b0;
    int vecs = 0;
    int errs = 0;
    muldiv_unit_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .nRst(nRst), .flush(flush), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.inputA = a;
        bus.inputB = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.inputA = 32'h5A5A_A5A5;
        bus.inputB = 32'hA5A5_5A5A;
    endtask
    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        @(negedge clk);
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        start(o, a, b);
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " result"}, bus.result, exp);
        chk({tag, " negative"}, 32'(bus.negative), 32'(exp[31]));
        chk({tag, " zero"}, 32'(bus.zero), 32'(exp == 32'd0));
        if (bus.out_ready) begin
            @(negedge clk);
            chk({tag, " pulse"}, 32'(bus.out_valid), 32'd0);
        end
    endtask
    initial begin
        int seen;
        bus.in_valid = 1'b0;
        bus.op = 3'b000;
        bus.inputA = '0;
        bus.inputB = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst result", bus.result, 32'd0);
        chk("rst zero", 32'(bus.zero), 32'd1);
        chk("rst negative", 32'(bus.negative), 32'd0);
        @(negedge clk);
        nRst = 1'b1;
        run("MUL", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run("DIV", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run("REM", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run("DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 34);
        run("REMU", 3'b111, 32'd100, 32'd7, 32'd2, 34);
        run("DIVU0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run("REMU0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
        run("DIVOVF", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("REMOVF", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        bus.out_ready = 1'b0;
        run("BP", 3'b101, 32'd100, 32'd7, 32'd14, 34);
        bus.in_valid = 1'b1;
        bus.op = 3'b000;
        bus.inputA = 32'd2;
        bus.inputB = 32'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("BP hold result", bus.result, 32'd14);
            chk("BP hold in_ready", 32'(bus.in_ready), 32'd0);
            chk("BP hold out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("BP release in_ready", 32'(bus.in_ready), 32'd1);
        chk("BP release out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("BP not queued", 32'(bus.out_valid), 32'd0);
        start(3'b000, 32'd9, 32'd9);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("FLUSH in_ready", 32'(bus.in_ready), 32'd1);
        chk("FLUSH out_valid", 32'(bus.out_valid), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen += int'(bus.out_valid);
        end
        chk("FLUSH no result", 32'(seen), 32'd0);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.op = 3'b101;
        bus.inputB = 32'd0;
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("FLUSH wins in_ready", 32'(bus.in_ready), 32'd1);
        chk("FLUSH wins out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        run("FLDONE", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("FLUSH done out_valid", 32'(bus.out_valid), 32'd0);
        chk("FLUSH done in_ready", 32'(bus.in_ready), 32'd1);
        start(3'b000, 32'd6, 32'd6);
        repeat (4) @(negedge clk);
        nRst = 1'b0;
        #1;
        chk("MIDRST in_ready", 32'(bus.in_ready), 32'd1);
        chk("MIDRST out_valid", 32'(bus.out_valid), 32'd0);
        chk("MIDRST result", bus.result, 32'd0);
        chk("MIDRST zero", 32'(bus.zero), 32'd1);
        chk("MIDRST negative", 32'(bus.negative), 32'd0);
        @(negedge clk);
        nRst = 1'b1;
        run("MUL34", 3'b000, 32'd3, 32'd4, 32'd12, 34);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
